// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per cycle,
// start/busy/done handshake, sticky overflow and optional leading-zero blanking.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int LZB    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  enable,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [4*DIGITS-1:0] scr_q, scr_d;
  logic [4*DIGITS-1:0] res_q, res_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sticky_q, sticky_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scr_sh;
  logic                sticky_sh;
  logic                seen;

  // Per-digit add-3 correction; 4-bit wrap is intended.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? scr_q[4*g +: 4] + 4'd3
                                                    : scr_q[4*g +: 4];
  end

  assign scr_sh    = {adj[4*DIGITS-2:0], shreg_q[WIDTH-1]};
  assign sticky_sh = sticky_q | adj[4*DIGITS-1];

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    scr_d    = scr_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d  = bin;
          scr_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        scr_d    = scr_sh;
        shreg_d  = shreg_q << 1;
        sticky_d = sticky_sh;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          res_d   = scr_sh;
          ovf_d   = sticky_sh;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      scr_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      scr_q    <= scr_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign ovf  = ovf_q;

  // Blank from the top down until the first nonzero digit; units always shown.
  always_comb begin
    bcd  = res_q;
    seen = 1'b0;
    if (LZB != 0) begin
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (res_q[4*i +: 4] != 4'd0) seen = 1'b1;
        if (!seen) bcd[4*i +: 4] = 4'hF;
      end
    end
    if (!enable) bcd = '1;
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: two converter instances (16b/5 digits with blanking, 8b/2 digits raw)
// checked every cycle against an arithmetic model of the displayed value.
module tb_bin_to_bcd_seq;

  localparam int WA = 16, DA = 5;
  localparam int WB = 8,  DB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start_a = 0, en_a = 1, busy_a, done_a, ovf_a;
  logic [WA-1:0]     bin_a = '0;
  logic [4*DA-1:0]   bcd_a;
  logic              start_b = 0, en_b = 1, busy_b, done_b, ovf_b;
  logic [WB-1:0]     bin_b = '0;
  logic [4*DB-1:0]   bcd_b;

  bin_to_bcd_seq #(.WIDTH(WA), .DIGITS(DA), .LZB(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a), .enable(en_a),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a));

  bin_to_bcd_seq #(.WIDTH(WB), .DIGITS(DB), .LZB(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b), .enable(en_b),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b));

  typedef struct { int val; int acc; } exp_t;
  exp_t qa[$], qb[$];
  int   last_a = 0, last_b = 0;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Displayed digits from plain decimal arithmetic: value mod 10^nd, blanking, enable mask.
  function automatic logic [19:0] disp(input int v, input int nd, input bit lzb, input bit en);
    logic [19:0] r;
    int top, d;
    r = '0;
    top = 0;
    for (int i = 0; i < nd; i++) begin
      d = (v / (10 ** i)) % 10;
      r[4*i +: 4] = d[3:0];
      if (d != 0) top = i;
    end
    if (lzb) for (int i = top + 1; i < nd; i++) r[4*i +: 4] = 4'hF;
    if (!en) for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'hF;
    return r;
  endfunction

  logic [19:0] ea, eb;

  always @(negedge clk) begin
    if (done_a) begin
      chk("done_a_pending", int'(qa.size() != 0), 1);
      if (qa.size() != 0) begin
        chk("done_a_latency", cyc, qa[0].acc + WA);
        last_a = qa[0].val;
        qa.pop_front();
      end
    end else if (qa.size() != 0 && cyc >= qa[0].acc + WA) begin
      chk("done_a_missing", int'(done_a), 1);
      qa.pop_front();
    end
    chk("busy_a", int'(busy_a),
        int'(qa.size() != 0 && cyc >= qa[0].acc && cyc < qa[0].acc + WA));
    ea = disp(last_a, DA, 1'b1, en_a);
    chk("bcd_a", int'(bcd_a), int'(ea));
    chk("ovf_a", int'(ovf_a), int'(last_a >= 100000));

    if (done_b) begin
      chk("done_b_pending", int'(qb.size() != 0), 1);
      if (qb.size() != 0) begin
        chk("done_b_latency", cyc, qb[0].acc + WB);
        last_b = qb[0].val;
        qb.pop_front();
      end
    end else if (qb.size() != 0 && cyc >= qb[0].acc + WB) begin
      chk("done_b_missing", int'(done_b), 1);
      qb.pop_front();
    end
    chk("busy_b", int'(busy_b),
        int'(qb.size() != 0 && cyc >= qb[0].acc && cyc < qb[0].acc + WB));
    eb = disp(last_b, DB, 1'b0, en_b);
    chk("bcd_b", int'(bcd_b), int'(eb[7:0]));
    chk("ovf_b", int'(ovf_b), int'(last_b >= 100));
  end

  // Issue one conversion on A and wait until it has completed.
  task automatic conv_a(input int v);
    @(posedge clk); #1;
    bin_a = v[WA-1:0]; start_a = 1;
    qa.push_back('{val: v, acc: cyc + 1});
    @(posedge clk); #1;
    start_a = 0;
    repeat (WA + 1) @(posedge clk);
  endtask

  task automatic conv_b(input int v);
    @(posedge clk); #1;
    bin_b = v[WB-1:0]; start_b = 1;
    qb.push_back('{val: v, acc: cyc + 1});
    @(posedge clk); #1;
    start_b = 0;
    repeat (WB + 1) @(posedge clk);
  endtask

  initial begin
    int acc1, v;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) @(posedge clk);

    conv_a(65535);
    conv_a(1234);
    conv_a(0);

    // Display disabled across a conversion; done still pulses.
    #1 en_a = 0;
    conv_a(999);
    repeat (3) @(posedge clk);
    #1 en_a = 1;
    repeat (2) @(posedge clk);

    conv_b(255);
    conv_b(99);
    conv_b(5);
    conv_b(100);

    // Start mid-conversion is ignored.
    @(posedge clk); #1;
    bin_a = 16'd4321; start_a = 1;
    qa.push_back('{val: 4321, acc: cyc + 1});
    @(posedge clk); #1 start_a = 0;
    repeat (4) @(posedge clk);
    #1 start_a = 1; bin_a = 16'd777;
    @(posedge clk); #1 start_a = 0;
    repeat (WA) @(posedge clk);

    // Start held through done: immediate second conversion.
    @(posedge clk); #1;
    bin_a = 16'd31415; start_a = 1;
    acc1 = cyc + 1;
    qa.push_back('{val: 31415, acc: acc1});
    qa.push_back('{val: 2718, acc: acc1 + WA + 1});
    @(posedge clk); #1 bin_a = 16'd2718;
    while (cyc < acc1 + WA + 1) @(posedge clk);
    #1 start_a = 0;
    repeat (WA + 2) @(posedge clk);

    // Reset mid-conversion aborts with no done.
    @(posedge clk); #1;
    bin_a = 16'd50000; start_a = 1;
    qa.push_back('{val: 50000, acc: cyc + 1});
    @(posedge clk); #1 start_a = 0;
    repeat (7) @(posedge clk);
    #1 rst_n = 0;
    qa.delete(); qb.delete();
    last_a = 0; last_b = 0;
    #6 rst_n = 1;
    repeat (2) @(posedge clk);
    conv_a(50000);

    // Random traffic with enable toggling mid-flight.
    for (int n = 0; n < 40; n++) begin
      v = int'($urandom_range(0, 65535));
      fork
        conv_a(v);
        begin
          repeat ($urandom_range(1, 15)) @(posedge clk);
          #2 en_a = 1'($urandom_range(0, 1));
        end
      join
      v = int'($urandom_range(0, 255));
      en_b = 1'($urandom_range(0, 1));
      conv_b(v);
    end
    #1 en_a = 1; en_b = 1;
    repeat (4) @(posedge clk);

    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
